pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 128: width of the pipelined datapath bundle (operands, addresses, immediates, rd).
REQ-002 Parameter CTRL_W, default 6: width of the pipelined control bundle (write enables, jump, branch, jalr, load).
REQ-003 Parameter CTRL_BUBBLE, default all-zero: control value presented on out_ctrl whenever out_valid=0.
REQ-004 Parameter CNT_W, default 16: width of the saturating stall counter.
REQ-005 The port list SHALL be as follows; reset reset, asynchronous, active-high; clock clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  kills all held entries; synchronous.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage can accept an entry; registered.
REQ-011 in_data  input  DATA_W  upstream datapath bundle.
REQ-012 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-013 out_valid  output  1  output entry present.
REQ-014 out_ready  input  1  downstream accepts the entry.
REQ-015 out_data  output  DATA_W  held datapath bundle.
REQ-016 out_ctrl  output  CTRL_W  held control bundle, or CTRL_BUBBLE when out_valid=0.
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Function
REQ-018 Transfers SHALL occur only on a rising edge where valid=1 and ready=1 on the same side; the input-to-output latency SHALL be exactly 1 cycle when the stage is empty.
REQ-019 Storage SHALL be one main register and one skid register, giving three states: EMPTY (none held), MAIN (main only), FULL (main and skid).
REQ-020 in_ready SHALL equal 1 in EMPTY and MAIN and 0 in FULL, and SHALL be driven from a flop with no combinational path from out_ready.
REQ-021 EMPTY -> MAIN on input accept; otherwise the stage SHALL remain in EMPTY.
REQ-022 MAIN with input accept and output accept SHALL load main from input and stay in MAIN.
REQ-023 MAIN with output accept only SHALL go to EMPTY.
REQ-024 MAIN with input accept only SHALL load skid and go to FULL.
REQ-025 FULL with output accept SHALL move skid to main and go to MAIN; without output accept, FULL SHALL hold.
REQ-026 Entries SHALL leave the stage in arrival order, with no loss and no duplication.
REQ-027 When out_valid=0, out_ctrl SHALL equal CTRL_BUBBLE; out_data is don't-care but SHALL hold its last value.
REQ-028 When flush=1 at an edge, the stage SHALL go to EMPTY regardless of other inputs.
REQ-029 An input accepted on a flush edge (in_valid=1, in_ready=1) SHALL be discarded.
REQ-030 After a flush edge, in_ready=1 on the following cycle.
REQ-031 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-032 While reset=1, the stage SHALL be in EMPTY with out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, in_ready=0 and stall_cnt=0.
REQ-033 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all held entries without producing any output transfer.

Structure
REQ-035 The state encoding (EMPTY/MAIN/FULL) and the default CTRL_BUBBLE constant SHALL reside in the shared pipeline package.
REQ-036 The block SHALL be a single module with no sub-modules; the per-stage pipeline instances (ID/EX, EX/MEM, MEM/WB) SHALL be instantiations of it with DATA_W, CTRL_W and CTRL_BUBBLE set per stage.

Verification
REQ-037 Streaming: out_ready=1, 8 back-to-back inputs with data 1..8 -> out_data 1..8 on consecutive cycles, each 1 cycle after its input, in_ready held at 1.
REQ-038 Backpressure: out_ready=0 with inputs A, B -> FULL and in_ready=0; then out_ready=1 -> A then B on consecutive cycles, in_ready=1 from the cycle after A leaves.
REQ-039 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1; no held or flush-cycle entry ever appears at the output.
REQ-040 Bubble control: CTRL_BUBBLE=6'b000001 and an idle input -> out_ctrl=000001 while out_valid=0.
REQ-041 Reset asserted asynchronously in FULL -> all outputs at reset values within the same cycle; stall_cnt=0.
REQ-042 CNT_W=4, out_ready=0 with a held entry for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and the default
// control bubble used by every inter-stage register (ID/EX, EX/MEM, MEM/WB).
package pipe_stage_skid_pkg;

  // EMPTY: nothing held; MAIN: main register holds the output entry;
  // FULL: main holds the output entry and skid holds the next one.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Default control bundle presented when no entry is held. Wide enough for
  // any control bundle in the pipeline; each stage casts it to its CTRL_W.
  localparam logic [63:0] CTRL_BUBBLE_DEFAULT = '0;

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer. in_ready is a
// flop, so the upstream handshake never depends combinationally on out_ready.
// A saturating counter records cycles in which the held entry was refused.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned          DATA_W      = 128,
  parameter int unsigned          CTRL_W      = 6,
  parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
  parameter int unsigned          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  skid_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              vld_p1;
  logic [DATA_W-1:0] main_data_p1, skid_data_p1;
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p1;
  logic [CNT_W-1:0]  stall_q;
  logic              in_acc, out_acc;
  logic              load_main_in, load_skid, move_skid;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = vld_p1 & out_ready;

  // State register; reset discards every held entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next state and register load strobes; flush overrides everything so
  // neither held entries nor a same-edge input survive.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_acc) begin
          state_d      = ST_MAIN;
          load_main_in = 1'b1;
        end
      end
      ST_MAIN: begin
        if (in_acc && out_acc) begin
          load_main_in = 1'b1;
        end else if (out_acc) begin
          state_d = ST_EMPTY;
        end else if (in_acc) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_acc) begin
          state_d   = ST_MAIN;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d      = ST_EMPTY;
      load_main_in = 1'b0;
      load_skid    = 1'b0;
      move_skid    = 1'b0;
    end
  end

  // Output decode: bubble control whenever nothing is held; in_ready is
  // precomputed from the next state so it can be registered.
  always_comb begin
    vld_p1     = (state_q != ST_EMPTY);
    out_ctrl   = vld_p1 ? main_ctrl_p1 : CTRL_BUBBLE;
    in_ready_d = (state_d != ST_FULL);
  end

  assign out_valid = vld_p1;
  assign out_data  = main_data_p1;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_q;

  // Registered in_ready: low during reset, rises on the first edge after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready_q <= 1'b0;
    else       in_ready_q <= in_ready_d;
  end

  // ---- stage p1: main register (output side), cleared so out_data=0 in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_p1 <= '0;
      main_ctrl_p1 <= '0;
    end else if (load_main_in) begin
      main_data_p1 <= in_data;
      main_ctrl_p1 <= in_ctrl;
    end else if (move_skid) begin
      main_data_p1 <= skid_data_p1;
      main_ctrl_p1 <= skid_ctrl_p1;
    end
  end

  // Skid register: only meaningful in FULL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= in_data;
      skid_ctrl_p1 <= in_ctrl;
    end
  end

  // Stall counter: counts refused output cycles, survives flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    stall_q <= '0;
    else if (vld_p1 && !out_ready) stall_q <= sat_inc(stall_q);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush,
// bubble control, asynchronous reset and stall counter saturation.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CTRL_W-1:0] BUBBLE = 6'b000001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUBBLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %0h want 0", out_data); end
    checks++; if (out_ctrl !== 6'b000001) begin errors++; $display("FAIL rst_ctrl got %b want 000001", out_ctrl); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %0b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      in_ctrl = 6'h20 | CTRL_W'(i);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_data !== DATA_W'(i)) begin errors++; $display("FAIL stream_data[%0d] got %0h want %0h", i, out_data, i); end
      checks++; if (out_ctrl !== (6'h20 | CTRL_W'(i))) begin errors++; $display("FAIL stream_ctrl[%0d] got %h want %h", i, out_ctrl, 6'h20 | CTRL_W'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %0b want 0", out_valid); end
    checks++; if (out_ctrl !== 6'b000001) begin errors++; $display("FAIL bubble_ctrl got %b want 000001", out_ctrl); end
    checks++; if (out_data !== 16'h0008) begin errors++; $display("FAIL bubble_data_hold got %0h want 8", out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00AA; in_ctrl = 6'h0A;
    step();
    in_data   = 16'h00BB; in_ctrl = 6'h0B;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
    checks++; if (out_data !== 16'h00AA) begin errors++; $display("FAIL bp_full_data got %0h want aa", out_data); end
    // C is offered while full and must not be taken
    in_data   = 16'h00CC; in_ctrl = 6'h0C;
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== 16'h00AA) begin errors++; $display("FAIL bp_hold got ready=%0b data=%0h want 0/aa", in_ready, out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00BB || out_ctrl !== 6'h0B) begin errors++; $display("FAIL bp_second got v=%0b d=%0h c=%h want 1/bb/0b", out_valid, out_data, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %0b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_c got valid=%0b data=%0h want valid 0", out_valid, out_data); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL bp_stall got %0d want 2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00D1; in_ctrl = 6'h11;
    step();
    in_data   = 16'h00E2; in_ctrl = 6'h12;
    step();
    checks++; if (in_ready !== 1'b0 || stall_cnt !== 4'd3) begin errors++; $display("FAIL flush_setup got ready=%0b stall=%0d want 0/3", in_ready, stall_cnt); end
    flush   = 1'b1;
    in_data = 16'h00F3; in_ctrl = 6'h13;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    checks++; if (out_ctrl !== 6'b000001) begin errors++; $display("FAIL flush_ctrl got %b want 000001", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready); end
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL flush_stall_kept got %0d want 4", stall_cnt); end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got valid=%0b data=%0h want 0", out_valid, out_data); end
    in_valid = 1'b1;
    in_data  = 16'h00C4; in_ctrl = 6'h14;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h00C4 || out_ctrl !== 6'h14) begin errors++; $display("FAIL flush_resume got v=%0b d=%0h c=%h want 1/c4/14", out_valid, out_data, out_ctrl); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_resume_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00A1; in_ctrl = 6'h21;
    step();
    in_data   = 16'h00B2; in_ctrl = 6'h22;
    step();
    in_valid  = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_full got ready=%0b want 0", in_ready); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 6'b000001) begin errors++; $display("FAIL ar_out got v=%0b c=%b want 0/000001", out_valid, out_ctrl); end
    checks++; if (out_data !== 16'h0000 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_data_ready got d=%0h r=%0b want 0/0", out_data, in_ready); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL ar_stall got %0d want 0", stall_cnt); end
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_release_ready got %0b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_after got r=%0b v=%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_stall_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5A5A; in_ctrl = 6'h3F;
    step();
    in_valid  = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_start got %0d want 0", stall_cnt); end
    repeat (5) step();
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL sat_mid got %0d want 5", stall_cnt); end
    repeat (15) step();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cap got %0d want 15", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin errors++; $display("FAIL sat_held got v=%0b d=%0h want 1/5a5a", out_valid, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_release got v=%0b stall=%0d want 0/15", out_valid, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stall_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
